prog_loader: RTL and testbench

- Byte-stream program loader; the write side of the CPU's 1024x16 instruction memory.
- Accepts a framed byte stream (word count, then big-endian instruction words) from a host link, such as a UART receiver.
- Writes each assembled 16-bit word to consecutive instruction addresses starting at 0.
- Holds the CPU in reset while a load is in progress and signals completion or error.

---
 rtl/prog_loader.sv | 163 ++++++++++++++++
 tb/tb_prog_loader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Byte-stream program loader: assembles big-endian words from a framed host stream into instruction memory.
// Optional trailing XOR checksum byte enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned WL_W  = ADDR_W + 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_WORD_HI,
    S_WORD_LO,
    S_WRITE,
    S_DONE,
`ifdef PROG_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_ERROR
  } state_t;

  state_t              state_q, state_d;
  logic                rx_ready_q, mem_we_q, cpu_hold_q, done_q, error_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_din_q;
  logic [WL_W-1:0]     words_loaded_q;
  logic [CNT_W-1:0]    count_q;
  logic [CNT_W-1:0]    count_d;
  logic                xfer;
  logic                last_word;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]          csum_q;
`endif

  assign xfer      = rx_valid && rx_ready_q;
  assign count_d   = {count_q[15:8], rx_data};
  assign last_word = (CNT_W'(words_loaded_q) + CNT_W'(1)) == count_q;

  // States in which the loader consumes bytes from the host link
  function automatic logic ready_state(input state_t s);
    logic r;
    r = (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_WORD_HI) || (s == S_WORD_LO);
`ifdef PROG_LOADER_CHECKSUM_EN
    r = r || (s == S_CHK);
`endif
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: if (start) state_d = S_LEN_HI;
      S_LEN_HI:  if (xfer) state_d = S_LEN_LO;
      S_LEN_LO: begin
        if (xfer) begin
          if (count_d == '0 || 32'(count_d) > MAX_WORDS) state_d = S_ERROR;
          else                                          state_d = S_WORD_HI;
        end
      end
      S_WORD_HI: if (xfer) state_d = S_WORD_LO;
      S_WORD_LO: if (xfer) state_d = S_WRITE;
      S_WRITE: begin
`ifdef PROG_LOADER_CHECKSUM_EN
        state_d = last_word ? S_CHK : S_WORD_HI;
`else
        state_d = last_word ? S_DONE : S_WORD_HI;
`endif
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHK: if (xfer) state_d = (rx_data == csum_q) ? S_DONE : S_ERROR;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet aligned with the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      rx_ready_q     <= 1'b0;
      mem_we_q       <= 1'b0;
      cpu_hold_q     <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      mem_addr_q     <= '0;
      mem_din_q      <= '0;
      words_loaded_q <= '0;
      count_q        <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q         <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rx_ready_q <= ready_state(state_d);
      mem_we_q   <= (state_d == S_WRITE);
      done_q     <= (state_d == S_DONE);
      error_q    <= (state_d == S_ERROR);
      cpu_hold_q <= (state_d != S_IDLE) && (state_d != S_DONE);
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            mem_addr_q     <= '0;
            words_loaded_q <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q         <= '0;
`endif
          end
        end
        S_LEN_HI: if (xfer) count_q[15:8] <= rx_data;
        S_LEN_LO: if (xfer) count_q[7:0]  <= rx_data;
        S_WORD_HI: begin
          if (xfer) begin
            mem_din_q[15:8] <= rx_data;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q          <= csum_q ^ rx_data;
`endif
          end
        end
        S_WORD_LO: begin
          if (xfer) begin
            mem_din_q[7:0] <= rx_data;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q         <= csum_q ^ rx_data;
`endif
          end
        end
        S_WRITE: begin
          mem_addr_q     <= mem_addr_q + ADDR_W'(1);
          words_loaded_q <= words_loaded_q + WL_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign rx_ready     = rx_ready_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_din      = mem_din_q;
  assign cpu_hold     = cpu_hold_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: scoreboard of expected memory writes plus per-scenario status checks.
module tb_prog_loader;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 16;

  typedef logic [7:0] bq_t[$];

  logic              clk = 1'b0;
  logic              rst, start, rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready, mem_we, cpu_hold, done, error;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [ADDR_W:0]   words_loaded;

  int checks = 0;
  int errors = 0;
  logic [ADDR_W+DATA_W-1:0] exp_q[$];

  prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WORDS(1024)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .cpu_hold(cpu_hold), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Write monitor: every strobe must match the next expected (addr,data) and occur with rx_ready low
  always @(negedge clk) begin
    if (mem_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0h data=%h, required no write", mem_addr, mem_din);
      end else begin
        logic [ADDR_W+DATA_W-1:0] e;
        e = exp_q.pop_front();
        if ({mem_addr, mem_din} !== e) begin
          errors++;
          $display("FAIL write: got addr=%0h data=%h, required addr=%0h data=%h",
                   mem_addr, mem_din, e[ADDR_W+DATA_W-1:DATA_W], e[DATA_W-1:0]);
        end
      end
      checks++;
      if (rx_ready !== 1'b0) begin
        errors++;
        $display("FAIL ready_in_write: got rx_ready=%b, required 0", rx_ready);
      end
    end
  end

  function automatic bq_t with_csum(input bq_t f);
    bq_t r;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] x;
`endif
    r = f;
`ifdef PROG_LOADER_CHECKSUM_EN
    x = 8'h00;
    for (int i = 2; i < f.size(); i++) x = x ^ f[i];
    r.push_back(x);
`endif
    return r;
  endfunction

  task automatic expect_words(input bq_t f, input int n);
    for (int k = 0; k < n; k++)
      exp_q.push_back({ADDR_W'(k), f[2+2*k], f[3+2*k]});
  endtask

  // Called at a negedge; returns at the negedge after the byte was consumed
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    if (gap > 0) begin
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    t = 0;
    while (!rx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: rx_ready stayed %b for byte %h, required 1", rx_ready, b);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_status(input string nm, input logic e_done, input logic e_err,
                              input logic e_hold, input int e_words);
    checks++;
    if (done !== e_done || error !== e_err || cpu_hold !== e_hold ||
        words_loaded !== (ADDR_W+1)'(e_words)) begin
      errors++;
      $display("FAIL %s: got done=%b error=%b cpu_hold=%b words=%0d, required %b %b %b %0d",
               nm, done, error, cpu_hold, words_loaded, e_done, e_err, e_hold, e_words);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_writes: got %0d pending, required 0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run_load(input string nm, input bq_t f, input int max_gap, input int start_idx,
                          input logic e_done, input int e_words);
    int t;
    pulse_start();
    for (int i = 0; i < f.size(); i++) begin
      if (i == start_idx) start = 1'b1;
      send_byte(f[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    end
    rx_valid = 1'b0;
    t = 0;
    while (!(done || error) && t < 20) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    check_status(nm, e_done, !e_done, !e_done, e_words);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({rx_ready, mem_we, mem_addr, mem_din, cpu_hold, done, error, words_loaded} !== '0) begin
      errors++;
      $display("FAIL reset_values: got rdy=%b we=%b addr=%0h din=%h hold=%b done=%b err=%b words=%0d, required all 0",
               rx_ready, mem_we, mem_addr, mem_din, cpu_hold, done, error, words_loaded);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bq_t f;
    f = '{8'h00, 8'h03, 8'hB2, 8'h37, 8'hB4, 8'h01, 8'hB6, 8'h55};
    expect_words(f, 3);
    run_load("basic", with_csum(f), 0, -1, 1'b1, 3);
  endtask

  task automatic test_illegal_count();
    bq_t f;
    f = '{8'h00, 8'h00};
    run_load("count_zero", f, 0, -1, 1'b0, 0);
    f = '{8'h04, 8'h01};
    run_load("count_1025", f, 0, -1, 1'b0, 0);
    f = '{8'h00, 8'h01, 8'h12, 8'h34};
    expect_words(f, 1);
    run_load("count_one", with_csum(f), 0, -1, 1'b1, 1);
  endtask

  task automatic test_backpressure();
    bq_t f;
    f = '{8'h00, 8'h03, 8'hB2, 8'h37, 8'hB4, 8'h01, 8'hB6, 8'h55};
    for (int r = 0; r < 3; r++) begin
      expect_words(f, 3);
      run_load("gaps", with_csum(f), 5, -1, 1'b1, 3);
    end
  endtask

  task automatic test_reset_mid_load();
    bq_t f;
    f = '{8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    expect_words(f, 2);
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(f[i], 0);
    rx_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({rx_ready, mem_we, mem_addr, mem_din, cpu_hold, done, error, words_loaded} !== '0) begin
      errors++;
      $display("FAIL reset_mid_load: got rdy=%b we=%b addr=%0h din=%h hold=%b done=%b err=%b words=%0d, required all 0",
               rx_ready, mem_we, mem_addr, mem_din, cpu_hold, done, error, words_loaded);
    end
    rst = 1'b0;
    @(negedge clk);
    check_status("reset_mid_idle", 1'b0, 1'b0, 1'b0, 0);
    expect_words(f, 4);
    run_load("after_reset", with_csum(f), 0, -1, 1'b1, 4);
  endtask

  task automatic test_start_mid_load();
    bq_t f;
    f = '{8'h00, 8'h03, 8'hA1, 8'hA2, 8'hB1, 8'hB2, 8'hC1, 8'hC2};
    expect_words(f, 3);
    run_load("start_mid", with_csum(f), 0, 5, 1'b1, 3);
  endtask

  task automatic test_checksum();
`ifdef PROG_LOADER_CHECKSUM_EN
    bq_t f;
    f = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    expect_words(f, 2);
    run_load("csum_good", f, 0, -1, 1'b1, 2);
    f = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
    expect_words(f, 2);
    run_load("csum_bad", f, 0, -1, 1'b0, 2);
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_illegal_count();
    test_backpressure();
    test_reset_mid_load();
    test_start_mid_load();
    test_checksum();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
